btn_led_ctrl_n: RTL and testbench
=================================

// Module: btn_led_ctrl_n
// PURPOSE
//   Parametrised button/LED controller, successor to the fixed 4-button main block.
//   Synchronises and debounces N_BTN raw buttons, emits one-cycle press pulses, and
//   drives N_LED LEDs from a counter, debounced levels, toggle bits or a running light.
//   Sits between the board pins (BTN/LEDS) and any higher-level game/timer logic.
// PARAMETERS
//   N_BTN      4   number of button channels (>= 3)
//   N_LED      4   number of LED outputs (>= 1)
//   DEB_CYC    4   consecutive stable cycles required to accept a level change (>= 1)
//   CNT_W      4   press-counter width; wraps modulo 2**CNT_W
// PORTS
//   clk     in   1        system clock, rising edge
//   reset   in   1        asynchronous, active-high reset
//   BTN     in   N_BTN    raw button levels, asynchronous to clk
//   MODE    in   2        LED source select, sampled every cycle
//   PRESS   out  N_BTN    one-cycle pulse per accepted rising edge, per channel
//   LEDS    out  N_LED    registered LED drive
// BEHAVIOUR
//   Reset (async): sync FFs, debounced levels, debounce counters, PRESS, count,
//     toggle register = 0; running-light pointer = 1 (bit 0); LEDS = 0.
//   Sync: 2-FF synchroniser per channel; no logic on the first stage.
//   Debounce per channel: cnt increments while sync != deb; cleared on any cycle
//     sync == deb; when cnt reaches DEB_CYC-1 with sync != deb, deb <= sync, cnt <= 0.
//     Pulses shorter than DEB_CYC sync'd cycles never change deb.
//   PRESS[i] registered = deb[i] & ~deb_prev[i]; high exactly 1 cycle; falling edges
//     produce nothing. Latency BTN edge -> PRESS high: 2 + DEB_CYC + 1 cycles.
//   Action decode (cycle after PRESS): ch0 = INC, ch1 = DEC, ch2 = CLR, ch>=3 toggle only.
//     CLR has priority: count <= 0, pointer <= 1, toggle unchanged.
//     INC & DEC same cycle (no CLR): count and pointer unchanged.
//     INC: count+1 mod 2**CNT_W, pointer rotate left (MSB wraps to bit 0).
//     DEC: count-1 mod 2**CNT_W, pointer rotate right (bit 0 wraps to MSB).
//     Every PRESS[i]: toggle[i] flips (including ch0..2).
//   LEDS (registered, 1 cycle after source register updates):
//     MODE 0: count   1: deb levels   2: toggle   3: running-light pointer.
//     Source narrower than N_LED -> zero-extended; wider -> low N_LED bits.
//   MODE change takes effect on LEDS the next cycle; no state is altered by MODE.
//   Held button: single PRESS only; no auto-repeat.
//   Reset mid-debounce or mid-press: all state cleared immediately; a button still
//     held when reset releases is debounced afresh and yields one PRESS.
// TESTING
//   Reset: assert reset 1 cycle, BTN=0 -> LEDS=0, PRESS=0, pointer=1 (MODE 3 -> LEDS=0001).
//   Press: DEB_CYC=4, MODE 0, BTN[0] high 10 cycles -> PRESS[0] one pulse at cycle 7,
//     LEDS=0001 two cycles later; three presses -> LEDS=0011.
//   Glitch: BTN[0] high 3 cycles (DEB_CYC=4) -> no PRESS, count stays 0.
//   Wrap: 15 INC presses then 1 more -> LEDS 1111 then 0000; DEC from 0 -> 1111.
//   Priority: PRESS[0] and PRESS[1] same cycle -> count unchanged; with BTN[2] too -> 0.
//   Modes: MODE 3, 4 INC presses -> LEDS 0010,0100,1000,0001; MODE 2 after BTN[3]
//     press -> bit 3 set; reset asserted mid-debounce -> no PRESS, LEDS=0.

Source files
------------

// File: rtl/btn_led_ctrl_n.sv
// Button front end (2-FF sync, debounce, press pulse) feeding a counter/toggle/running-light LED driver.
// BTN edge -> PRESS is 2 + DEB_CYC + 1 cycles; LEDS follow their source register by one cycle.
module btn_led_ctrl_n #(
    parameter int N_BTN   = 4,
    parameter int N_LED   = 4,
    parameter int DEB_CYC = 4,
    parameter int CNT_W   = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [N_BTN-1:0] BTN,
    input  logic [1:0]       MODE,
    output logic [N_BTN-1:0] PRESS,
    output logic [N_LED-1:0] LEDS
);

    localparam int            DW       = (DEB_CYC > 1) ? $clog2(DEB_CYC) : 1;
    localparam logic [DW-1:0] DEB_LAST = DW'(DEB_CYC - 1);

    logic [N_BTN-1:0] sync1_q, sync2_q;
    logic [N_BTN-1:0] deb_q, deb_d, deb_prev_q;
    logic [DW-1:0]    dcnt_q [N_BTN];
    logic [DW-1:0]    dcnt_d [N_BTN];
    logic [N_BTN-1:0] press_q, press_d;
    logic [N_BTN-1:0] tog_q, tog_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [N_LED-1:0] ptr_q, ptr_d;
    logic [N_LED-1:0] leds_q, leds_d;

    logic inc, dec, clr;

    // Counter only advances while the synced level disagrees with the accepted level.
    always_comb begin
        deb_d = deb_q;
        for (int i = 0; i < N_BTN; i++) begin
            dcnt_d[i] = '0;
            if (sync2_q[i] != deb_q[i]) begin
                if (dcnt_q[i] == DEB_LAST) begin
                    deb_d[i] = sync2_q[i];
                end else begin
                    dcnt_d[i] = dcnt_q[i] + DW'(1);
                end
            end
        end
    end

    assign press_d = deb_q & ~deb_prev_q;

    assign inc = press_q[0];
    assign dec = press_q[1];
    assign clr = press_q[2];

    always_comb begin
        count_d = count_q;
        ptr_d   = ptr_q;
        if (clr) begin
            count_d = '0;
            ptr_d   = N_LED'(1);
        end else if (inc && !dec) begin
            count_d = count_q + CNT_W'(1);
            ptr_d   = (ptr_q << 1) | (ptr_q >> (N_LED - 1));
        end else if (dec && !inc) begin
            count_d = count_q - CNT_W'(1);
            ptr_d   = (ptr_q >> 1) | (ptr_q << (N_LED - 1));
        end
    end

    assign tog_d = tog_q ^ press_q;

    // Size casts give zero-extension for narrow sources and low-bit truncation for wide ones.
    always_comb begin
        leds_d = '0;
        case (MODE)
            2'd0:    leds_d = N_LED'(count_q);
            2'd1:    leds_d = N_LED'(deb_q);
            2'd2:    leds_d = N_LED'(tog_q);
            default: leds_d = ptr_q;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1_q    <= '0;
            sync2_q    <= '0;
            deb_q      <= '0;
            deb_prev_q <= '0;
            for (int i = 0; i < N_BTN; i++) begin
                dcnt_q[i] <= '0;
            end
            press_q    <= '0;
            tog_q      <= '0;
            count_q    <= '0;
            ptr_q      <= N_LED'(1);
            leds_q     <= '0;
        end else begin
            sync1_q    <= BTN;
            sync2_q    <= sync1_q;
            deb_q      <= deb_d;
            deb_prev_q <= deb_q;
            for (int i = 0; i < N_BTN; i++) begin
                dcnt_q[i] <= dcnt_d[i];
            end
            press_q    <= press_d;
            tog_q      <= tog_d;
            count_q    <= count_d;
            ptr_q      <= ptr_d;
            leds_q     <= leds_d;
        end
    end

    assign PRESS = press_q;
    assign LEDS  = leds_q;

endmodule

// File: tb/tb_btn_led_ctrl_n.sv
// Bench for btn_led_ctrl_n: directed scenarios plus random button/mode traffic against a timeline model.
module tb_btn_led_ctrl_n;

    localparam int N_BTN   = 4;
    localparam int N_LED   = 4;
    localparam int DEB_CYC = 4;
    localparam int CNT_W   = 4;
    localparam int MAXT    = 8192;

    logic             clk   = 1'b0;
    logic             reset = 1'b1;
    logic [N_BTN-1:0] BTN   = '0;
    logic [1:0]       MODE  = 2'd0;
    logic [N_BTN-1:0] PRESS;
    logic [N_LED-1:0] LEDS;

    btn_led_ctrl_n #(
        .N_BTN  (N_BTN),
        .N_LED  (N_LED),
        .DEB_CYC(DEB_CYC),
        .CNT_W  (CNT_W)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .BTN  (BTN),
        .MODE (MODE),
        .PRESS(PRESS),
        .LEDS (LEDS)
    );

    always #5 clk = ~clk;

    int errors     = 0;
    int checks     = 0;
    int t          = 0;
    int press_seen = 0;

    // Timeline of the reference model, indexed by clock edge since reset release.
    logic [N_BTN-1:0] in_h    [MAXT];
    logic [1:0]       mode_h  [MAXT];
    logic [N_BTN-1:0] deb_h   [MAXT];
    logic [N_BTN-1:0] press_h [MAXT];
    logic [N_BTN-1:0] tog_h   [MAXT];
    int               count_h [MAXT];
    int               pos_h   [MAXT];
    logic [N_LED-1:0] leds_h  [MAXT];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int cl(input int k);
        return (k < 0) ? 0 : k;
    endfunction

    task automatic model_step();
        int               k;
        int               m;
        int               src;
        logic [N_BTN-1:0] d;
        logic [N_BTN-1:0] p;
        k = t;
        m = 1 << CNT_W;
        // A level is accepted once the last DEB_CYC synchronised samples all disagree with it.
        d = deb_h[k-1];
        for (int i = 0; i < N_BTN; i++) begin
            bit all_diff;
            all_diff = 1'b1;
            for (int j = 0; j < DEB_CYC; j++) begin
                if (in_h[cl(k-2-j)][i] == d[i]) all_diff = 1'b0;
            end
            deb_h[k][i] = all_diff ? ~d[i] : d[i];
        end
        press_h[k] = deb_h[k-1] & ~deb_h[cl(k-2)];
        p = press_h[k-1];
        count_h[k] = count_h[k-1];
        pos_h[k]   = pos_h[k-1];
        if (p[2]) begin
            count_h[k] = 0;
            pos_h[k]   = 0;
        end else if (p[0] && !p[1]) begin
            count_h[k] = (count_h[k-1] + 1) % m;
            pos_h[k]   = (pos_h[k-1] + 1) % N_LED;
        end else if (p[1] && !p[0]) begin
            count_h[k] = (count_h[k-1] + m - 1) % m;
            pos_h[k]   = (pos_h[k-1] + N_LED - 1) % N_LED;
        end
        tog_h[k] = tog_h[k-1] ^ p;
        case (mode_h[k])
            2'd0:    src = count_h[k-1];
            2'd1:    src = int'(deb_h[k-1]);
            2'd2:    src = int'(tog_h[k-1]);
            default: src = 1 << pos_h[k-1];
        endcase
        leds_h[k] = N_LED'(src % (1 << N_LED));
    endtask

    task automatic tick();
        @(posedge clk);
        if (t >= MAXT - 1) begin
            $display("FAIL model_overflow: got t=%0d expected below %0d", t, MAXT - 1);
            $fatal(1, "model timeline exhausted");
        end
        t++;
        in_h[t]   = BTN;
        mode_h[t] = MODE;
        model_step();
        @(negedge clk);
        if (PRESS != '0) press_seen++;
        chk($sformatf("press@%0d", t), 32'(PRESS), 32'(press_h[t]));
        chk($sformatf("leds@%0d", t), 32'(LEDS), 32'(leds_h[t]));
    endtask

    task automatic do_reset();
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("rst_press", 32'(PRESS), 32'd0);
        chk("rst_leds", 32'(LEDS), 32'd0);
        reset      = 1'b0;
        t          = 0;
        in_h[0]    = '0;
        mode_h[0]  = 2'd0;
        deb_h[0]   = '0;
        press_h[0] = '0;
        tog_h[0]   = '0;
        count_h[0] = 0;
        pos_h[0]   = 0;
        leds_h[0]  = '0;
    endtask

    task automatic press(input logic [N_BTN-1:0] mask, input int hold);
        BTN = mask;
        repeat (hold) tick();
        BTN = '0;
        repeat (12) tick();
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int p_at;
        int ps0;

        // Single press: latency and count
        do_reset();
        MODE = 2'd0;
        BTN  = 4'b0001;
        p_at = -1;
        ps0  = press_seen;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (PRESS[0] && p_at < 0) p_at = t;
            if (t == 9) chk("leds_t9", 32'(LEDS), 32'd1);
        end
        BTN = '0;
        repeat (12) tick();
        chk("press_lat", 32'(p_at), 32'd7);
        chk("one_pulse", 32'(press_seen - ps0), 32'd1);
        chk("cnt1", 32'(LEDS), 32'd1);
        press(4'b0001, 8);
        press(4'b0001, 8);
        chk("cnt3", 32'(LEDS), 32'd3);

        // Glitch shorter than the debounce window
        do_reset();
        MODE = 2'd0;
        ps0  = press_seen;
        BTN  = 4'b0001;
        repeat (3) tick();
        BTN = '0;
        repeat (10) tick();
        chk("glitch_press", 32'(press_seen - ps0), 32'd0);
        chk("glitch_cnt", 32'(LEDS), 32'd0);

        // Counter wrap in both directions
        do_reset();
        MODE = 2'd0;
        repeat (15) press(4'b0001, 8);
        chk("wrap15", 32'(LEDS), 32'd15);
        press(4'b0001, 8);
        chk("wrap16", 32'(LEDS), 32'd0);
        press(4'b0010, 8);
        chk("dec0", 32'(LEDS), 32'd15);

        // INC/DEC collision and CLR priority
        do_reset();
        MODE = 2'd0;
        press(4'b0001, 8);
        press(4'b0001, 8);
        press(4'b0011, 8);
        chk("incdec", 32'(LEDS), 32'd2);
        press(4'b0111, 8);
        chk("clr_prio", 32'(LEDS), 32'd0);

        // Running light and toggle view
        do_reset();
        MODE = 2'd3;
        tick();
        chk("ptr_rst", 32'(LEDS), 32'd1);
        press(4'b0001, 8);
        chk("ptr1", 32'(LEDS), 32'd2);
        press(4'b0001, 8);
        chk("ptr2", 32'(LEDS), 32'd4);
        press(4'b0001, 8);
        chk("ptr3", 32'(LEDS), 32'd8);
        press(4'b0001, 8);
        chk("ptr4", 32'(LEDS), 32'd1);
        MODE = 2'd2;
        press(4'b1000, 8);
        chk("tog3", 32'(LEDS[3]), 32'd1);

        // Reset in the middle of debouncing with the button still held
        do_reset();
        MODE = 2'd0;
        BTN  = 4'b0001;
        repeat (4) tick();
        ps0 = press_seen;
        do_reset();
        repeat (10) tick();
        BTN = '0;
        repeat (12) tick();
        chk("held_pulses", 32'(press_seen - ps0), 32'd1);
        chk("held_cnt", 32'(LEDS), 32'd1);

        // Random traffic against the model
        do_reset();
        repeat (150) begin
            MODE = 2'($urandom_range(0, 3));
            BTN  = N_BTN'($urandom);
            repeat ($urandom_range(1, 10)) tick();
            if ($urandom_range(0, 1) == 1) BTN = '0;
            repeat ($urandom_range(1, 8)) tick();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
